// File: rtl/ej32_pkg.sv
// eJ32 shared types, opcode table and sequencer helpers.
// Phase counts and unit ownership per opcode live here.
package ej32_pkg;

  localparam int EJ32_ASZ = 17;
  localparam int EJ32_DSZ = 32;
  localparam int EJ32_PHW = 3;

  typedef logic [7:0] opcode_t;

  localparam opcode_t OP_NOP    = 8'h00;
  localparam opcode_t OP_ILOAD  = 8'h15;
  localparam opcode_t OP_ISTORE = 8'h36;
  localparam opcode_t OP_IADD   = 8'h60;
  localparam opcode_t OP_IMUL   = 8'h68;
  localparam opcode_t OP_IFEQ   = 8'h99;
  localparam opcode_t OP_GOTO   = 8'hA7;
  localparam opcode_t OP_JSR    = 8'hA8;
  localparam opcode_t OP_HALT   = 8'hFF;

  typedef enum logic [1:0] {
    BOOT,
    EXEC,
    HALT
  } seq_st_t;

  typedef enum logic [1:0] {
    U_NONE,
    U_AU,
    U_BR,
    U_LS
  } unit_t;

  // Unknown opcodes run as a single-phase nop.
  function automatic logic [3:0] nphase(opcode_t op);
    case (op)
      OP_ILOAD:  return 4'd2;
      OP_ISTORE: return 4'd2;
      OP_IMUL:   return 4'd3;
      OP_IFEQ:   return 4'd3;
      OP_GOTO:   return 4'd3;
      OP_JSR:    return 4'd3;
      default:   return 4'd1;
    endcase
  endfunction

  function automatic unit_t unit_of(opcode_t op);
    case (op)
      OP_IADD:   return U_AU;
      OP_IMUL:   return U_AU;
      OP_ILOAD:  return U_LS;
      OP_ISTORE: return U_LS;
      OP_IFEQ:   return U_BR;
      OP_GOTO:   return U_BR;
      OP_JSR:    return U_BR;
      default:   return U_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ej32_tos_arb.sv
// TOS write arbiter: fixed priority BR > LS > AU,
// flags a conflict when two or more units request together.
module ej32_tos_arb
  import ej32_pkg::*;
#(
  parameter int DSZ = EJ32_DSZ
) (
  input  logic           en_i,
  input  logic           au_x_i,
  input  logic [DSZ-1:0] au_t_i,
  input  logic           ls_x_i,
  input  logic [DSZ-1:0] ls_t_i,
  input  logic           br_x_i,
  input  logic [DSZ-1:0] br_t_i,
  output logic           sel_o,
  output logic [DSZ-1:0] t_o,
  output logic           cflt_o
);

  always_comb begin
    sel_o = 1'b0;
    t_o   = '0;
    if (en_i) begin
      priority case (1'b1)
        br_x_i: begin sel_o = 1'b1; t_o = br_t_i; end
        ls_x_i: begin sel_o = 1'b1; t_o = ls_t_i; end
        au_x_i: begin sel_o = 1'b1; t_o = au_t_i; end
        default: ;
      endcase
    end
  end

  assign cflt_o = en_i & ((au_x_i & ls_x_i) |
                          (au_x_i & br_x_i) |
                          (ls_x_i & br_x_i));

endmodule

// File: rtl/ej32_seq.sv
// eJ32 instruction sequencer: opcode latch, phase counter,
// instruction pointer and arbitrated TOS register.
module ej32_seq
  import ej32_pkg::*;
#(
  parameter int ASZ = EJ32_ASZ,
  parameter int DSZ = EJ32_DSZ,
  parameter int PHW = EJ32_PHW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hold,
  input  logic [7:0]     data,
  input  logic [DSZ-1:0] au_t,
  input  logic           au_t_x,
  input  logic [DSZ-1:0] ls_t,
  input  logic           ls_t_x,
  input  logic [DSZ-1:0] br_t,
  input  logic           br_t_x,
  input  logic [ASZ-1:0] br_p,
  input  logic           br_psel,
  output opcode_t        code,
  output logic [PHW-1:0] phase,
  output logic [ASZ-1:0] p,
  output logic [DSZ-1:0] t,
  output logic           au_en,
  output logic           br_en,
  output logic           ls_en,
  output logic           halt,
  output logic           t_cflt
);

  seq_st_t        state_q, state_d;
  opcode_t        code_q, code_d;
  logic [PHW-1:0] phase_q, phase_d;
  logic [ASZ-1:0] p_q, p_d;
  logic [DSZ-1:0] t_q, t_d;

  logic           run;
  logic           last;
  logic           arb_sel;
  logic [DSZ-1:0] arb_t;
  logic           arb_cflt;

  assign run  = (state_q == EXEC) & ~hold;
  assign last = (phase_q == PHW'(nphase(code_q) - 4'd1));

  ej32_tos_arb #(
    .DSZ (DSZ)
  ) u_arb (
    .en_i   (run),
    .au_x_i (au_t_x),
    .au_t_i (au_t),
    .ls_x_i (ls_t_x),
    .ls_t_i (ls_t),
    .br_x_i (br_t_x),
    .br_t_i (br_t),
    .sel_o  (arb_sel),
    .t_o    (arb_t),
    .cflt_o (arb_cflt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: if (!hold)
        state_d = (data == OP_HALT) ? HALT : EXEC;
      EXEC: if (run && !br_psel && last && data == OP_HALT)
        state_d = HALT;
      HALT: state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    code_d  = code_q;
    phase_d = phase_q;
    p_d     = p_q;
    t_d     = t_q;
    if (state_q == BOOT && !hold) begin
      code_d = data;
      p_d    = p_q + ASZ'(1);
    end
    if (run) begin
      p_d = br_psel ? br_p : p_q + ASZ'(1);
      // A redirect drops into a nop bubble that fetches the target.
      if (br_psel) begin
        code_d  = OP_NOP;
        phase_d = '0;
      end else if (last) begin
        code_d  = data;
        phase_d = '0;
      end else begin
        phase_d = phase_q + PHW'(1);
      end
      if (arb_sel) t_d = arb_t;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q  <= OP_NOP;
      phase_q <= '0;
      p_q     <= '0;
      t_q     <= '0;
    end else begin
      code_q  <= code_d;
      phase_q <= phase_d;
      p_q     <= p_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    au_en = 1'b0;
    br_en = 1'b0;
    ls_en = 1'b0;
    if (run) begin
      unique case (unit_of(code_q))
        U_AU:    au_en = 1'b1;
        U_BR:    br_en = 1'b1;
        U_LS:    ls_en = 1'b1;
        default: ;
      endcase
    end
  end

  assign halt   = (state_q == HALT);
  assign t_cflt = arb_cflt;
  assign code   = code_q;
  assign phase  = phase_q;
  assign p      = p_q;
  assign t      = t_q;

endmodule

// File: tb/tb_ej32_seq.sv
// Directed bench for ej32_seq: fetch, redirect, TOS arbitration,
// hold, pointer wrap, halt and async reset.
module tb_ej32_seq;
  import ej32_pkg::*;

  localparam int ASZ = 17;
  localparam int DSZ = 32;
  localparam int PHW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           hold;
  logic [7:0]     data;
  logic [DSZ-1:0] au_t, ls_t, br_t;
  logic           au_t_x, ls_t_x, br_t_x;
  logic [ASZ-1:0] br_p;
  logic           br_psel;
  opcode_t        code;
  logic [PHW-1:0] phase;
  logic [ASZ-1:0] p;
  logic [DSZ-1:0] t;
  logic           au_en, br_en, ls_en, halt, t_cflt;

  logic [7:0] mem [0:(1<<ASZ)-1];

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign data = mem[p];

  ej32_seq dut (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .data    (data),
    .au_t    (au_t),
    .au_t_x  (au_t_x),
    .ls_t    (ls_t),
    .ls_t_x  (ls_t_x),
    .br_t    (br_t),
    .br_t_x  (br_t_x),
    .br_p    (br_p),
    .br_psel (br_psel),
    .code    (code),
    .phase   (phase),
    .p       (p),
    .t       (t),
    .au_en   (au_en),
    .br_en   (br_en),
    .ls_en   (ls_en),
    .halt    (halt),
    .t_cflt  (t_cflt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_code"}, code, 8'h00);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_p"}, p, 0);
    chk({tag, "_t"}, t, 0);
    chk({tag, "_en"}, {au_en, br_en, ls_en}, 3'b000);
    chk({tag, "_halt"}, halt, 0);
    chk({tag, "_cflt"}, t_cflt, 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'h00;
    mem[17'h10]    = OP_GOTO;
    mem[17'h40]    = OP_IADD;
    mem[17'h50]    = OP_IMUL;
    mem[17'h1FFFF] = OP_IADD;
    rst = 1'b1; hold = 1'b0;
    au_t = '0; ls_t = '0; br_t = '0;
    au_t_x = 1'b0; ls_t_x = 1'b0; br_t_x = 1'b0;
    br_p = '0; br_psel = 1'b0;
    #2 rst = 1'b0;
    #2 chk_rst("rst0");
    @(posedge clk); #1 rst = 1'b1;

    // 1: boot and sequential fetch of nops
    tick();
    chk("boot_p", p, 1);
    chk("boot_code", code, 8'h00);
    chk("boot_en", {au_en, br_en, ls_en}, 3'b000);
    tick();
    chk("seq_p2", p, 2);
    tick();
    chk("seq_p3", p, 3);
    chk("seq_en", {au_en, br_en, ls_en}, 3'b000);

    // 2: goto at 0x10 redirected to 0x40
    begin
      int n = 0;
      while (code !== OP_GOTO && n < 40) begin tick(); n++; end
    end
    chk("goto_code", code, OP_GOTO);
    chk("goto_p", p, 17'h11);
    chk("goto_ph0_br", br_en, 1);
    tick();
    chk("goto_ph1", phase, 1);
    chk("goto_ph1_br", br_en, 1);
    tick();
    chk("goto_ph2", phase, 2);
    chk("goto_ph2_p", p, 17'h13);
    br_psel = 1'b1; br_p = 17'h40;
    #1 chk("goto_ph2_br", br_en, 1);
    tick();
    br_psel = 1'b0;
    chk("redir_p", p, 17'h40);
    chk("redir_code", code, 8'h00);
    chk("redir_phase", phase, 0);
    chk("redir_br", br_en, 0);
    tick();
    chk("tgt_code", code, OP_IADD);
    chk("tgt_p", p, 17'h41);
    chk("tgt_en", {au_en, br_en, ls_en}, 3'b100);

    // 3: TOS arbitration
    au_t_x = 1'b1; au_t = 5; br_t_x = 1'b1; br_t = 9;
    #1 chk("cflt_on", t_cflt, 1);
    tick();
    chk("t_br_wins", t, 9);
    br_t_x = 1'b0; au_t = 7;
    #1 chk("cflt_off", t_cflt, 0);
    tick();
    chk("t_au", t, 7);
    ls_t_x = 1'b1; ls_t = 3;
    #1 chk("cflt_ls_au", t_cflt, 1);
    tick();
    chk("t_ls_wins", t, 3);
    au_t_x = 1'b0; ls_t_x = 1'b0;

    // 4: hold inside a 3-phase op
    br_psel = 1'b1; br_p = 17'h50;
    tick();
    br_psel = 1'b0;
    chk("imul_redir_p", p, 17'h50);
    tick();
    chk("imul_code", code, OP_IMUL);
    tick();
    chk("imul_ph1", phase, 1);
    chk("imul_ph1_p", p, 17'h52);
    hold = 1'b1; au_t_x = 1'b1; au_t = 32'h55; ls_t_x = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_en", {au_en, br_en, ls_en}, 3'b000);
      chk("hold_cflt", t_cflt, 0);
      tick();
      chk("hold_phase", phase, 1);
      chk("hold_p", p, 17'h52);
      chk("hold_t", t, 3);
    end
    hold = 1'b0; au_t_x = 1'b0; ls_t_x = 1'b0;
    #1 chk("resume_en", au_en, 1);
    tick();
    chk("resume_ph2", phase, 2);
    chk("resume_p", p, 17'h53);
    tick();
    chk("imul_done_ph", phase, 0);
    chk("imul_done_code", code, 8'h00);
    chk("imul_done_p", p, 17'h54);

    // 5: pointer wrap, then halt
    mem[0] = 8'h00;
    mem[1] = OP_HALT;
    br_psel = 1'b1; br_p = 17'h1FFFF;
    tick();
    br_psel = 1'b0;
    chk("wrap_pre_p", p, 17'h1FFFF);
    tick();
    chk("wrap_p", p, 0);
    chk("wrap_code", code, OP_IADD);
    chk("wrap_phase", phase, 0);
    tick();
    chk("pre_halt_p", p, 1);
    chk("pre_halt", halt, 0);
    tick();
    chk("halt_on", halt, 1);
    chk("halt_code", code, OP_HALT);
    chk("halt_p", p, 2);
    br_psel = 1'b1; br_p = 17'h77; br_t_x = 1'b1; br_t = 32'hAB;
    tick();
    tick();
    chk("halt_sticky", halt, 1);
    chk("halt_p_frz", p, 2);
    chk("halt_t_frz", t, 3);
    chk("halt_en", {au_en, br_en, ls_en}, 3'b000);
    br_psel = 1'b0; br_t_x = 1'b0;

    // 6: async reset mid-jsr, then restart
    mem[0] = OP_JSR;
    mem[1] = 8'h00;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    chk("jsr_code", code, OP_JSR);
    chk("jsr_br", br_en, 1);
    tick();
    tick();
    chk("jsr_ph2", phase, 2);
    br_t_x = 1'b1; br_t = 32'hAA;
    rst = 1'b0;
    #2 chk_rst("async");
    @(negedge clk) begin rst = 1'b1; br_t_x = 1'b0; end
    tick();
    chk("restart_code", code, OP_JSR);
    chk("restart_p", p, 1);
    chk("restart_t", t, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
